// File: rtl/am_trainer_hf.sv
// Associative-memory trainer: per-class bit and sample counters, majority-thresholded
// into registered non-seizure / seizure prototype hypervectors on request.
module am_trainer_hf #(
  parameter int unsigned DIMENSIONS = 10000,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  label_in,
  input  logic [DIMENSIONS-1:0] hv,
  input  logic                  finalize,
  input  logic                  clear,
  output logic [DIMENSIONS-1:0] ns_hv,
  output logic [DIMENSIONS-1:0] s_hv,
  output logic                  out,
  output logic                  busy
);

  typedef enum logic {StTrain, StFinal} state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_ns_q [DIMENSIONS];
  logic [CNT_WIDTH-1:0] cnt_s_q  [DIMENSIONS];
  logic [CNT_WIDTH-1:0] n_ns_q;
  logic [CNT_WIDTH-1:0] n_s_q;

  logic                  train_ns;
  logic                  train_s;
  logic [DIMENSIONS-1:0] ns_thr;
  logic [DIMENSIONS-1:0] s_thr;

  // A saturated class drops the whole sample so bit counters never exceed n.
  always_comb begin
    train_ns = (state_q == StTrain) && !clear && en && !label_in && (n_ns_q != CntMax);
    train_s  = (state_q == StTrain) && !clear && en &&  label_in && (n_s_q  != CntMax);
  end

  // Majority vote evaluated one bit wider so 2*count cannot wrap; ties resolve to 0.
  always_comb begin
    ns_thr = '0;
    s_thr  = '0;
    for (int i = 0; i < DIMENSIONS; i++) begin
      ns_thr[i] = {cnt_ns_q[i], 1'b0} > {1'b0, n_ns_q};
      s_thr[i]  = {cnt_s_q[i], 1'b0}  > {1'b0, n_s_q};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      n_ns_q <= '0;
      n_s_q  <= '0;
      for (int i = 0; i < DIMENSIONS; i++) begin
        cnt_ns_q[i] <= '0;
        cnt_s_q[i]  <= '0;
      end
    end else if ((state_q == StTrain) && clear) begin
      n_ns_q <= '0;
      n_s_q  <= '0;
      for (int i = 0; i < DIMENSIONS; i++) begin
        cnt_ns_q[i] <= '0;
        cnt_s_q[i]  <= '0;
      end
    end else begin
      if (train_ns) begin
        n_ns_q <= n_ns_q + CntOne;
        for (int i = 0; i < DIMENSIONS; i++) begin
          if (hv[i]) cnt_ns_q[i] <= cnt_ns_q[i] + CntOne;
        end
      end
      if (train_s) begin
        n_s_q <= n_s_q + CntOne;
        for (int i = 0; i < DIMENSIONS; i++) begin
          if (hv[i]) cnt_s_q[i] <= cnt_s_q[i] + CntOne;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StTrain;
      ns_hv   <= '0;
      s_hv    <= '1;
      out     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state_q)
        StTrain: begin
          out <= 1'b0;
          if (finalize && !clear) begin
            state_q <= StFinal;
            busy    <= 1'b1;
          end
        end
        StFinal: begin
          state_q <= StTrain;
          busy    <= 1'b0;
          out     <= 1'b1;
          // An untrained class has no majority to take; keep its old prototype.
          if (n_ns_q != '0) ns_hv <= ns_thr;
          if (n_s_q  != '0) s_hv  <= s_thr;
        end
        default: begin
          state_q <= StTrain;
          busy    <= 1'b0;
          out     <= 1'b0;
        end
      endcase
    end
  end

endmodule
